// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and default widths for the vending controller
package vend_pkg;

    localparam int CREDIT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCEPT   = 3'd1,
        ST_SETUP    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } state_t;

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - front-end/demux signal bundle; sold_out exists only with STOCK_TRACK_EN
interface vend_if
    import vend_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEF
) ();

    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_value;
    logic                sel_valid;
    logic [1:0]          sel;
    logic                cancel;
    logic [1:0]          slot_sel;
    logic                dispense_en;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                coin_reject;
    logic                deny;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
`ifdef STOCK_TRACK_EN
    logic [3:0]          sold_out;
`endif

    modport master (
`ifdef STOCK_TRACK_EN
        input  sold_out,
`endif
        output coin_valid, coin_value, sel_valid, sel, cancel,
        input  slot_sel, dispense_en, change_valid, change_amt,
        input  coin_reject, deny, credit, busy
    );

    modport slave (
`ifdef STOCK_TRACK_EN
        output sold_out,
`endif
        input  coin_valid, coin_value, sel_valid, sel, cancel,
        output slot_sel, dispense_en, change_valid, change_amt,
        output coin_reject, deny, credit, busy
    );

endinterface

// File: rtl/vend_stock.sv
// rtl/vend_stock.sv - per-slot stock counters and registered sold_out flags (STOCK_TRACK_EN builds only)
`ifdef STOCK_TRACK_EN
module vend_stock #(
    parameter logic [3:0] STOCK_INIT = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_dec,
    input  logic [1:0] i_slot,
    output logic [3:0] o_sold_out
);

    logic [3:0] r_stock [4];
    logic [3:0] w_nxt_stock [4];
    logic [3:0] r_sold_out;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_nxt_stock[i] = r_stock[i];
        end
        if (i_dec && (r_stock[i_slot] != 4'd0)) begin
            w_nxt_stock[i_slot] = r_stock[i_slot] - 4'd1;
        end
    end

    // sold_out is registered from the next count so it flips on the same edge as the decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_stock[i]    <= STOCK_INIT;
                r_sold_out[i] <= (STOCK_INIT == 4'd0);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_stock[i]    <= w_nxt_stock[i];
                r_sold_out[i] <= (w_nxt_stock[i] == 4'd0);
            end
        end
    end

    assign o_sold_out = r_sold_out;

endmodule
`endif

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending sequencer: credit, selection, demux gating, change; STOCK_TRACK_EN adds stock limits
module vend_controller
    import vend_pkg::*;
#(
    parameter int                  CREDIT_W    = CREDIT_W_DEF,
    parameter logic [CREDIT_W-1:0] PRICE0      = CREDIT_W'(25),
    parameter logic [CREDIT_W-1:0] PRICE1      = CREDIT_W'(50),
    parameter logic [CREDIT_W-1:0] PRICE2      = CREDIT_W'(75),
    parameter logic [CREDIT_W-1:0] PRICE3      = CREDIT_W'(100),
`ifdef STOCK_TRACK_EN
    parameter logic [3:0]          STOCK_INIT  = 4'd8,
`endif
    parameter int                  DISP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    vend_if.slave bus
);

    localparam int                CNT_W    = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DISP_CYCLES - 1);

    state_t              r_state, w_nxt_state;
    logic [CREDIT_W-1:0] r_credit, w_nxt_credit;
    logic [1:0]          r_slot_sel, w_nxt_slot_sel;
    logic                r_disp_en, w_nxt_disp_en;
    logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
    logic                r_change_valid, w_nxt_change_valid;
    logic [CREDIT_W-1:0] r_change_amt, w_nxt_change_amt;
    logic                r_coin_reject, w_nxt_coin_reject;
    logic                r_deny, w_nxt_deny;
    logic                r_busy, w_nxt_busy;

    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_sel_price;
    logic [CREDIT_W-1:0] w_vend_price;
    logic [CREDIT_W-1:0] w_remain;
    logic                w_vend_done;
    logic [3:0]          w_sold_out;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] s);
        case (s)
            2'd0:    return PRICE0;
            2'd1:    return PRICE1;
            2'd2:    return PRICE2;
            default: return PRICE3;
        endcase
    endfunction

    // one extra bit on the sum exposes overflow instead of wrapping the credit
    assign w_sum        = {1'b0, r_credit} + {1'b0, bus.coin_value};
    assign w_sel_price  = price_of(bus.sel);
    assign w_vend_price = price_of(r_slot_sel);
    assign w_remain     = r_credit - w_vend_price;
    assign w_vend_done  = (r_state == ST_DISPENSE) && (r_cnt == CNT_LAST);

`ifdef STOCK_TRACK_EN
    vend_stock #(
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk        (clk),
        .rst        (rst),
        .i_dec      (w_vend_done),
        .i_slot     (r_slot_sel),
        .o_sold_out (w_sold_out)
    );
    assign bus.sold_out = w_sold_out;
`else
    assign w_sold_out = 4'b0000;
`endif

    always_comb begin
        w_nxt_state        = r_state;
        w_nxt_credit       = r_credit;
        w_nxt_slot_sel     = r_slot_sel;
        w_nxt_disp_en      = 1'b0;
        w_nxt_cnt          = '0;
        w_nxt_change_valid = 1'b0;
        w_nxt_change_amt   = '0;
        w_nxt_coin_reject  = 1'b0;
        w_nxt_deny         = 1'b0;

        case (r_state)
            ST_IDLE, ST_ACCEPT: begin
                // cancel outranks selection, which outranks a coin in the same cycle
                if (bus.cancel) begin
                    w_nxt_coin_reject = bus.coin_valid;
                    if (r_state == ST_ACCEPT) begin
                        w_nxt_state        = ST_CHANGE;
                        w_nxt_change_valid = 1'b1;
                        w_nxt_change_amt   = r_credit;
                    end
                end else if (bus.sel_valid) begin
                    w_nxt_coin_reject = bus.coin_valid;
                    if ((r_state == ST_ACCEPT) && (r_credit >= w_sel_price) &&
                        !w_sold_out[bus.sel]) begin
                        w_nxt_slot_sel = bus.sel;
                        w_nxt_state    = ST_SETUP;
                    end else begin
                        w_nxt_deny = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (w_sum[CREDIT_W]) begin
                        w_nxt_coin_reject = 1'b1;
                    end else begin
                        w_nxt_credit = w_sum[CREDIT_W-1:0];
                        if (w_sum[CREDIT_W-1:0] != '0) begin
                            w_nxt_state = ST_ACCEPT;
                        end
                    end
                end
            end

            ST_SETUP: begin
                w_nxt_coin_reject = bus.coin_valid;
                w_nxt_state       = ST_DISPENSE;
                w_nxt_disp_en     = 1'b1;
            end

            ST_DISPENSE: begin
                w_nxt_coin_reject = bus.coin_valid;
                if (r_cnt == CNT_LAST) begin
                    w_nxt_state  = ST_CHANGE;
                    w_nxt_credit = w_remain;
                    if (w_remain != '0) begin
                        w_nxt_change_valid = 1'b1;
                        w_nxt_change_amt   = w_remain;
                    end
                end else begin
                    w_nxt_disp_en = 1'b1;
                    w_nxt_cnt     = r_cnt + 1'b1;
                end
            end

            ST_CHANGE: begin
                w_nxt_coin_reject = bus.coin_valid;
                w_nxt_credit      = '0;
                w_nxt_state       = ST_IDLE;
            end

            default: begin
                w_nxt_credit = '0;
                w_nxt_state  = ST_IDLE;
            end
        endcase

        w_nxt_busy = (w_nxt_state == ST_SETUP) || (w_nxt_state == ST_DISPENSE) ||
                     (w_nxt_state == ST_CHANGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_slot_sel     <= 2'd0;
            r_disp_en      <= 1'b0;
            r_cnt          <= '0;
            r_change_valid <= 1'b0;
            r_change_amt   <= '0;
            r_coin_reject  <= 1'b0;
            r_deny         <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_credit       <= w_nxt_credit;
            r_slot_sel     <= w_nxt_slot_sel;
            r_disp_en      <= w_nxt_disp_en;
            r_cnt          <= w_nxt_cnt;
            r_change_valid <= w_nxt_change_valid;
            r_change_amt   <= w_nxt_change_amt;
            r_coin_reject  <= w_nxt_coin_reject;
            r_deny         <= w_nxt_deny;
            r_busy         <= w_nxt_busy;
        end
    end

    assign bus.slot_sel     = r_slot_sel;
    assign bus.dispense_en  = r_disp_en;
    assign bus.change_valid = r_change_valid;
    assign bus.change_amt   = r_change_amt;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.deny         = r_deny;
    assign bus.credit       = r_credit;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed plus randomized bench against a timeline reference model
module tb_vend_controller;

    localparam int CW   = 8;
    localparam int D    = 4;
    localparam int CMAX = 255;
    localparam int SINIT = 1;
    localparam int P [4] = '{25, 50, 75, 100};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_if #(.CREDIT_W(CW)) bus ();

    vend_controller #(
        .CREDIT_W    (CW),
`ifdef STOCK_TRACK_EN
        .STOCK_INIT  (4'(SINIT)),
`endif
        .DISP_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // model: m_phase counts cycles since an accepted selection (0 = not busy)
    int m_credit, m_phase, m_price, m_slot;
    int m_stock [4];
    int e_rej, e_deny, e_chg, e_amt;
    int n_checks, n_fail;

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_phase = 0; m_price = 0; m_slot = 0;
        e_rej = 0; e_deny = 0; e_chg = 0; e_amt = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = SINIT;
    endtask

    task automatic model_step(input bit cv, input int val, input bit sv, input int s, input bit can);
        bit ok;
        e_rej = 0; e_deny = 0; e_chg = 0; e_amt = 0;
        if (m_phase > 0) begin
            e_rej = cv;
            m_phase++;
            if (m_phase == D + 2) begin
                m_credit -= m_price;
`ifdef STOCK_TRACK_EN
                m_stock[m_slot]--;
`endif
                if (m_credit > 0) begin e_chg = 1; e_amt = m_credit; end
            end else if (m_phase == D + 3) begin
                m_credit = 0;
                m_phase  = 0;
            end
        end else if (can) begin
            e_rej = cv;
            if (m_credit > 0) begin
                m_phase = D + 2;
                e_chg = 1;
                e_amt = m_credit;
            end
        end else if (sv) begin
            e_rej = cv;
            ok = 1'b1;
`ifdef STOCK_TRACK_EN
            ok = (m_stock[s] > 0);
`endif
            if (m_credit > 0 && m_credit >= P[s] && ok) begin
                m_phase = 1;
                m_price = P[s];
                m_slot  = s;
            end else begin
                e_deny = 1;
            end
        end else if (cv) begin
            if (m_credit + val > CMAX) e_rej = 1;
            else m_credit += val;
        end
    endtask

    task automatic check_all();
        check_val("credit",       bus.credit,       m_credit);
        check_val("busy",         bus.busy,         (m_phase > 0) ? 1 : 0);
        check_val("dispense_en",  bus.dispense_en,  (m_phase >= 2 && m_phase <= D + 1) ? 1 : 0);
        check_val("slot_sel",     bus.slot_sel,     m_slot);
        check_val("change_valid", bus.change_valid, e_chg);
        check_val("change_amt",   bus.change_amt,   e_amt);
        check_val("coin_reject",  bus.coin_reject,  e_rej);
        check_val("deny",         bus.deny,         e_deny);
`ifdef STOCK_TRACK_EN
        for (int i = 0; i < 4; i++)
            check_val("sold_out", bus.sold_out[i], (m_stock[i] == 0) ? 1 : 0);
`endif
    endtask

    task automatic step(input bit cv, input int val, input bit sv, input int s, input bit can);
        bus.coin_valid = cv;
        bus.coin_value = 8'(val);
        bus.sel_valid  = sv;
        bus.sel        = 2'(s);
        bus.cancel     = can;
        @(posedge clk);
        model_step(cv, val, sv, s, can);
        #1;
        check_all();
        bus.coin_valid = 1'b0;
        bus.coin_value = '0;
        bus.sel_valid  = 1'b0;
        bus.sel        = '0;
        bus.cancel     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    // reset is raised mid-cycle so the asynchronous clear is observed before any edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int cv, val, sv, s, can;
        n_checks = 0;
        n_fail   = 0;
        bus.coin_valid = 1'b0;
        bus.coin_value = '0;
        bus.sel_valid  = 1'b0;
        bus.sel        = '0;
        bus.cancel     = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        step(1, 25, 0, 0, 0);
        step(1, 50, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        idle(D + 4);

        step(1, 25, 0, 0, 0);
        step(0, 0, 1, 3, 0);
        idle(1);
        step(0, 0, 0, 0, 1);
        idle(3);

        step(1, 100, 0, 0, 0);
        step(1, 100, 0, 0, 0);
        step(1, 50, 0, 0, 0);
        step(1, 10, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        idle(3);
        step(1, 100, 0, 0, 0);
        step(0, 0, 1, 3, 0);
        idle(D + 4);

        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 25, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 25, 0, 0, 0);
        step(1, 25, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(D + 4);
        step(1, 50, 0, 0, 0);
        step(1, 25, 1, 0, 1);
        idle(3);

        step(1, 25, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(2);
        do_reset();
        idle(D + 4);

`ifdef STOCK_TRACK_EN
        do_reset();
        step(1, 25, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(D + 4);
        step(1, 25, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        idle(3);
`endif

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cv  = ($urandom_range(0, 3) == 0) ? 1 : 0;
                case ($urandom_range(0, 5))
                    0:       val = $urandom_range(0, 255);
                    1:       val = 5;
                    2:       val = 10;
                    3:       val = 50;
                    4:       val = 100;
                    default: val = 25;
                endcase
                sv  = ($urandom_range(0, 5) == 0) ? 1 : 0;
                s   = $urandom_range(0, 3);
                can = ($urandom_range(0, 24) == 0) ? 1 : 0;
                step(cv[0], val, sv[0], s, can[0]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
